piso_bit_feeder: RTL and testbench

//  Parallel-in/serial-out stage that feeds the serial "111" sequence detector.

---
 rtl/piso_bit_feeder_pkg.sv | 11 +
 rtl/piso_bit_feeder_if.sv | 32 +++
 rtl/piso_bit_feeder_bit_counter.sv | 42 ++++
 rtl/piso_bit_feeder.sv | 92 +++++++++
 tb/tb_piso_bit_feeder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/piso_bit_feeder_pkg.sv
// Shared state encoding and default word width for the serial bit feeder and its detector benches.
package piso_bit_feeder_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } feeder_state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage : piso_bit_feeder_pkg

// File: rtl/piso_bit_feeder_if.sv
// Word-in / bit-out bundle between the upstream word source, the feeder and the serial detector.
interface piso_bit_feeder_if #(
    parameter int WIDTH = piso_bit_feeder_pkg::DEFAULT_WIDTH
);
    logic [WIDTH-1:0] par_in;
    logic             par_valid;
    logic             par_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output par_in,
        output par_valid,
        input  par_ready,
        input  ser_out,
        input  ser_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  par_in,
        input  par_valid,
        output par_ready,
        output ser_out,
        output ser_valid,
        output word_done,
        output busy
    );
endinterface : piso_bit_feeder_if

// File: rtl/piso_bit_feeder_bit_counter.sv
// Bit position counter for the feeder: counts 0..WIDTH-1 and flags the final position.
// Latency: last is a flop, high during the cycle in which the count equals WIDTH-1.
// Backpressure: none; clr wins over en, and the count wraps to 0 after WIDTH-1.
module bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last_q ? '0 : cnt_q + CW'(1);
        end
        // Registered so word_done leaves the block straight from a flop.
        last_d = (cnt_d == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign last = last_q;

endmodule : bit_counter

// File: rtl/piso_bit_feeder.sv
// Serialises WIDTH-bit words into a gap-free bit stream for the "111" detector.
// Latency: first bit on ser_out the cycle after accept; one bit per clock, WIDTH bits per word.
// Backpressure: par_ready only in IDLE or on the last bit, so back-to-back words chain with no bubble.
module piso_bit_feeder
    import piso_bit_feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    piso_bit_feeder_if.slave    bus
);
    feeder_state_e    state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic             head;
    logic             last;
    logic             ready;
    logic             load;
    logic             cnt_clr;
    logic             cnt_en;

    // After WIDTH shifts the register is all zeros, so head reads 0 whenever idle.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
        assign head    = shreg_q[WIDTH-1];
    end else begin : g_lsb_first
        assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
        assign head    = shreg_q[0];
    end

    assign ready = (state_q == ST_IDLE) | last;
    assign load  = bus.par_valid & ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SHIFT;
                    shreg_d = bus.par_in;
                end
            end
            ST_SHIFT: begin
                if (load) begin
                    shreg_d = bus.par_in;
                end else begin
                    shreg_d = shifted;
                    if (last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    assign cnt_clr = (state_d == ST_IDLE) | load;
    assign cnt_en  = (state_q == ST_SHIFT);

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (last)
    );

    assign bus.par_ready = ready;
    assign bus.ser_out   = head;
    assign bus.ser_valid = (state_q == ST_SHIFT);
    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.word_done = last;

endmodule : piso_bit_feeder

// File: tb/tb_piso_bit_feeder.sv
// Directed bench for piso_bit_feeder: one MSB-first and one LSB-first instance on a shared clock/reset.
module tb_piso_bit_feeder;
    import piso_bit_feeder_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic clk = 1'b0;
    logic rst;
    bit   clk_en = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int run   = 0;

    piso_bit_feeder_if #(.WIDTH(W)) m_if ();
    piso_bit_feeder_if #(.WIDTH(W)) l_if ();

    piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_if.slave)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One serial cycle of the MSB-first instance; also feeds the bench's "111" run model.
    task automatic msb_bit(input string t, input int i, input logic b, input logic done, input logic rdy);
        chk($sformatf("%s[%0d].ser_valid", t, i), 32'(m_if.ser_valid), 32'd1);
        chk($sformatf("%s[%0d].ser_out", t, i), 32'(m_if.ser_out), 32'(b));
        chk($sformatf("%s[%0d].word_done", t, i), 32'(m_if.word_done), 32'(done));
        chk($sformatf("%s[%0d].par_ready", t, i), 32'(m_if.par_ready), 32'(rdy));
        chk($sformatf("%s[%0d].busy", t, i), 32'(m_if.busy), 32'd1);
        run = (m_if.ser_valid && m_if.ser_out) ? run + 1 : 0;
    endtask

    task automatic idle_chk(input string t);
        chk({t, ".ser_valid"}, 32'(m_if.ser_valid), 32'd0);
        chk({t, ".ser_out"}, 32'(m_if.ser_out), 32'd0);
        chk({t, ".word_done"}, 32'(m_if.word_done), 32'd0);
        chk({t, ".busy"}, 32'(m_if.busy), 32'd0);
        chk({t, ".par_ready"}, 32'(m_if.par_ready), 32'd1);
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] pair;

        rst            = 1'b0;
        m_if.par_in    = '0;
        m_if.par_valid = 1'b0;
        l_if.par_in    = '0;
        l_if.par_valid = 1'b0;

        // 1: reset held, no clock edges yet
        #2;
        idle_chk("rst_hold");
        chk("rst_hold.lsb_ser_valid", 32'(l_if.ser_valid), 32'd0);
        chk("rst_hold.lsb_par_ready", 32'(l_if.par_ready), 32'd1);
        #1 rst = 1'b1;
        clk_en = 1'b1;
        tick();

        // 2: E7 MSB-first, detector fires on the 3rd bit
        w = 8'hE7;
        m_if.par_in = w; m_if.par_valid = 1'b1;
        tick();
        m_if.par_valid = 1'b0;
        run = 0;
        for (int i = 0; i < 8; i++) begin
            msb_bit("e7", i, w[7-i], i == 7, i == 7);
            if (i == 1) chk("e7.det_before3", 32'(run >= 3), 32'd0);
            if (i == 2) chk("e7.det_after3", 32'(run >= 3), 32'd1);
            tick();
        end
        idle_chk("e7_after");

        // 3: 03 then C0 back-to-back, run of ones straddles the word edge
        pair = 16'h03C0;
        m_if.par_in = 8'h03; m_if.par_valid = 1'b1;
        tick();
        run = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) m_if.par_in = 8'hC0;
            msb_bit("b2b", i, pair[15-i], (i % 8) == 7, (i % 8) == 7);
            if (i == 7) chk("b2b.det_pre_edge", 32'(run >= 3), 32'd0);
            if (i == 8) chk("b2b.det_across_edge", 32'(run >= 3), 32'd1);
            if (i == 8) m_if.par_valid = 1'b0;
            tick();
        end
        idle_chk("b2b_after");

        // 4: FF offered at bit 3 of 5A must wait for the last bit
        w = 8'h5A;
        m_if.par_in = w; m_if.par_valid = 1'b1;
        tick();
        m_if.par_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                m_if.par_in = 8'hFF; m_if.par_valid = 1'b1;
            end
            msb_bit("early", i, w[7-i], i == 7, i == 7);
            tick();
        end
        m_if.par_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            msb_bit("ff", i, 1'b1, i == 7, i == 7);
            tick();
        end
        idle_chk("ff_after");

        // 5: asynchronous reset at bit 4 of AA, then 80
        w = 8'hAA;
        m_if.par_in = w; m_if.par_valid = 1'b1;
        tick();
        m_if.par_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            msb_bit("aa", i, w[7-i], 1'b0, 1'b0);
            if (i < 4) tick();
        end
        #2 rst = 1'b0;
        #1;
        idle_chk("aa_rst");
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_chk($sformatf("aa_post[%0d]", i));
        end
        w = 8'h80;
        m_if.par_in = w; m_if.par_valid = 1'b1;
        tick();
        m_if.par_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            msb_bit("w80", i, w[7-i], i == 7, i == 7);
            tick();
        end
        idle_chk("w80_after");

        // 6: LSB-first 01
        w = 8'h01;
        l_if.par_in = w; l_if.par_valid = 1'b1;
        tick();
        l_if.par_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb[%0d].ser_valid", i), 32'(l_if.ser_valid), 32'd1);
            chk($sformatf("lsb[%0d].ser_out", i), 32'(l_if.ser_out), 32'(w[i]));
            chk($sformatf("lsb[%0d].word_done", i), 32'(l_if.word_done), 32'(i == 7));
            tick();
        end
        chk("lsb_after.ser_valid", 32'(l_if.ser_valid), 32'd0);
        chk("lsb_after.ser_out", 32'(l_if.ser_out), 32'd0);
        chk("lsb_after.word_done", 32'(l_if.word_done), 32'd0);
        chk("lsb_after.par_ready", 32'(l_if.par_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_piso_bit_feeder
